// File: rtl/reg_display_pkg.sv
// Shared constants and helpers for the register-file hex display.
// Anode patterns are 32 wide and sliced down to DIGITS by the users.
package reg_display_pkg;

  localparam logic [31:0] AN_OFF  = '1;
  localparam logic [31:0] AN_DIG0 = ~32'd1;

  function automatic int num_digits(int bits);
    return (bits + 3) / 4;
  endfunction

endpackage

// File: rtl/reg_file_scan_display_if.sv
// Display bundle between the register-file read port and the digit scanner.
// The scanner owns nib/an/first; the read word comes from the file.
interface reg_file_scan_display_if #(
  parameter int BITS   = 16,
  parameter int DIGITS = 8
);
  logic [BITS-1:0]   word;
  logic [3:0]        nib;
  logic [DIGITS-1:0] an;
  logic              first;

  modport master (output word, input nib, an, first);
  modport slave  (input word, output nib, an, first);
endinterface

// File: rtl/hex2sseg.sv
// Hex nibble to active-low seven-segment pattern, bit order gfedcba.
module hex2sseg (
  input  logic [3:0] hex,
  output logic [6:0] sseg
);
  always_comb begin
    sseg = 7'h7f;
    case (hex)
      4'h0: sseg = 7'h40;
      4'h1: sseg = 7'h79;
      4'h2: sseg = 7'h24;
      4'h3: sseg = 7'h30;
      4'h4: sseg = 7'h19;
      4'h5: sseg = 7'h12;
      4'h6: sseg = 7'h02;
      4'h7: sseg = 7'h78;
      4'h8: sseg = 7'h00;
      4'h9: sseg = 7'h10;
      4'ha: sseg = 7'h08;
      4'hb: sseg = 7'h03;
      4'hc: sseg = 7'h46;
      4'hd: sseg = 7'h21;
      4'he: sseg = 7'h06;
      default: sseg = 7'h0e;
    endcase
  end
endmodule

// File: rtl/reg_file.sv
// 2^N x BITS register file: synchronous write, combinational read.
// Contents are deliberately not reset.
module reg_file #(
  parameter int N    = 7,
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            we,
  input  logic [N-1:0]    address_w,
  input  logic [N-1:0]    address_r,
  input  logic [BITS-1:0] data_w,
  output logic [BITS-1:0] data_r
);
  logic [BITS-1:0] mem [2**N];

  always_ff @(posedge clk) begin
    if (we) mem[address_w] <= data_w;
  end

  assign data_r = mem[address_r];
endmodule

// File: rtl/reg_file_scan_display_sseg_scan.sv
// Digit scanner: refresh counter, digit index, registered nibble and anodes.
// Digits above the word's width are blanked.
module sseg_scan
  import reg_display_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int DIGITS    = 8,
  parameter int REFRESH_W = 17
) (
  input logic clk,
  input logic reset,
  reg_file_scan_display_if.slave bus
);
  localparam int ND    = num_digits(BITS);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W = 4 * DIGITS;

  logic [REFRESH_W-1:0] refresh;
  logic [IDX_W-1:0]     idx;
  logic [EXT_W-1:0]     ext;

  assign ext       = EXT_W'(bus.word);
  assign bus.first = (idx == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh <= '0;
      idx     <= '0;
      bus.an  <= AN_DIG0[DIGITS-1:0];
      bus.nib <= '0;
    end else begin
      refresh <= refresh + REFRESH_W'(1);
      if (&refresh)
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      bus.an  <= (int'(idx) < ND) ? ~(DIGITS'(1) << idx)
                                  : AN_OFF[DIGITS-1:0];
      bus.nib <= ext[{idx, 2'b00} +: 4];
    end
  end
endmodule

// File: rtl/reg_file_scan_display.sv
// Register file with latched read/write addresses and a hex scan display.
// Define REG_FILE_SCAN_EN for auto-scanning of the read address (mode=1).
module reg_file_scan_display
  import reg_display_pkg::*;
#(
  parameter int N          = 7,
  parameter int BITS       = 16,
  parameter int DIGITS     = 8,
  parameter int REFRESH_W  = 17,
  parameter int SCAN_TICKS = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      address,
  input  logic [BITS-1:0]   data_w,
  input  logic              WE,
  input  logic              choose,
  input  logic              mode,
  output logic [6:0]        bcd,
  output logic [DIGITS-1:0] AN,
  output logic              DP
);
  logic [N-1:0]    address_w;
  logic [N-1:0]    address_r;
  logic [BITS-1:0] data_r;

  reg_file_scan_display_if #(.BITS(BITS), .DIGITS(DIGITS)) disp ();

  assign disp.word = data_r;
  assign AN        = disp.an;

  reg_file #(.N(N), .BITS(BITS)) u_rf (
    .clk       (clk),
    .we        (WE & ~reset),
    .address_w (address_w),
    .address_r (address_r),
    .data_w    (data_w),
    .data_r    (data_r)
  );

  sseg_scan #(
    .BITS      (BITS),
    .DIGITS    (DIGITS),
    .REFRESH_W (REFRESH_W)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .bus   (disp)
  );

  hex2sseg u_hex (.hex(disp.nib), .sseg(bcd));

  always_ff @(posedge clk) begin
    if (reset)        address_w <= '0;
    else if (!choose) address_w <= address;
  end

`ifdef REG_FILE_SCAN_EN
  localparam int SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic              dp_q;

  // An explicit load beats the scan tick and restarts the dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      address_r <= '0;
      scan_cnt  <= '0;
      dp_q      <= 1'b1;
    end else begin
      dp_q <= ~(mode & disp.first);
      if (choose) begin
        address_r <= address;
        scan_cnt  <= '0;
      end else if (!mode) begin
        scan_cnt <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        address_r <= address_r + N'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

  assign DP = dp_q;
`else
  logic scan_unused;

  assign scan_unused = mode | disp.first;

  always_ff @(posedge clk) begin
    if (reset)       address_r <= '0;
    else if (choose) address_r <= address;
  end

  assign DP = 1'b1;
`endif
endmodule

// File: tb/tb_reg_file_scan_display.sv
// Directed bench for reg_file_scan_display (BITS=16, REFRESH_W=2).
// Scan scenarios are selected by REG_FILE_SCAN_EN.
module tb_reg_file_scan_display;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  address = '0;
  logic [15:0] data_w = '0;
  logic        we = 1'b0;
  logic        choose = 1'b0;
  logic        mode = 1'b0;
  logic [6:0]  bcd;
  logic [7:0]  an;
  logic        dp;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  always #5 clk = ~clk;

  reg_file_scan_display #(
    .N(7), .BITS(16), .DIGITS(8), .REFRESH_W(2), .SCAN_TICKS(4)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data_w(data_w),
    .WE(we), .choose(choose), .mode(mode),
    .bcd(bcd), .AN(an), .DP(dp)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'ha: s = 7'h08; 4'hb: s = 7'h03;
      4'hc: s = 7'h46; 4'hd: s = 7'h21; 4'he: s = 7'h06; default: s = 7'h0e;
    endcase
    return s;
  endfunction

  // k edges after reset: index shown = ((k-1)/4) mod 8.
  function automatic logic [7:0] exp_an(int kk);
    int i;
    if (kk == 0) return 8'hfe;
    i = ((kk - 1) / 4) % 8;
    return (i < 4) ? ~(8'd1 << i) : 8'hff;
  endfunction

  function automatic logic [3:0] nib_of(logic [15:0] w, int kk);
    int i;
    i = ((kk - 1) / 4) % 8;
    return (i < 4) ? w[i*4 +: 4] : 4'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    we = 0; choose = 0; mode = 0; address = 7'd3;
    do_reset();
    n_cmp++;
    if (an !== 8'hfe) begin
      n_err++; $display("FAIL reset_an: got %h want fe", an);
    end
    n_cmp++;
    if (dp !== 1'b1) begin
      n_err++; $display("FAIL reset_dp: got %b want 1", dp);
    end
    n_cmp++;
    if (dut.address_r !== 7'd0) begin
      n_err++; $display("FAIL reset_ar: got %0d want 0", dut.address_r);
    end
    n_cmp++;
    if (dut.address_w !== 7'd0) begin
      n_err++; $display("FAIL reset_aw: got %0d want 0", dut.address_w);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    choose = 0; address = 7'd5;
    tick();
    we = 1; data_w = 16'ha3c1;
    tick();
    we = 0; choose = 1;
    tick();
    choose = 0; address = 7'd0;
    n_cmp++;
    if (dut.address_r !== 7'd5) begin
      n_err++; $display("FAIL wr_ar: got %0d want 5", dut.address_r);
    end
    for (int j = 0; j < 32; j++) begin
      tick();
      n_cmp++;
      if (an !== exp_an(k)) begin
        n_err++; $display("FAIL wr_an k=%0d: got %h want %h", k, an, exp_an(k));
      end
      n_cmp++;
      if (bcd !== seg(nib_of(16'ha3c1, k))) begin
        n_err++;
        $display("FAIL wr_bcd k=%0d: got %h want %h",
                 k, bcd, seg(nib_of(16'ha3c1, k)));
      end
      n_cmp++;
      if (dp !== 1'b1) begin
        n_err++; $display("FAIL wr_dp k=%0d: got %b want 1", k, dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 40; j++) begin
      tick();
      if (exp_an(k) == 8'hfb) break;
    end
    n_cmp++;
    if (an !== 8'hfb) begin
      n_err++; $display("FAIL mid_pre_an: got %h want fb", an);
    end
    do_reset();
    n_cmp++;
    if (an !== 8'hfe || dp !== 1'b1) begin
      n_err++; $display("FAIL mid_an_dp: got %h/%b want fe/1", an, dp);
    end
    n_cmp++;
    if (dut.address_r !== 7'd0) begin
      n_err++; $display("FAIL mid_ar: got %0d want 0", dut.address_r);
    end
    choose = 1; address = 7'd5;
    tick();
    choose = 0;
    tick();
    n_cmp++;
    if (bcd !== 7'h79) begin
      n_err++; $display("FAIL mid_keep: got %h want 79", bcd);
    end
  endtask

  task automatic test_write_displayed();
    do_reset();
    choose = 0; address = 7'd5;
    tick();
    choose = 1; we = 1; data_w = 16'hbeef;
    tick();
    choose = 0; we = 0;
    while (k < 33) tick();
    n_cmp++;
    if (bcd !== 7'h0e) begin
      n_err++; $display("FAIL wd_before: got %h want 0e", bcd);
    end
    we = 1; data_w = 16'h0001;
    tick();
    we = 0;
    n_cmp++;
    if (bcd !== 7'h0e) begin
      n_err++; $display("FAIL wd_edge: got %h want 0e", bcd);
    end
    tick();
    n_cmp++;
    if (bcd !== 7'h79 || an !== 8'hfe) begin
      n_err++; $display("FAIL wd_after: got %h/%h want 79/fe", bcd, an);
    end
  endtask

  task automatic test_reset_priority();
    choose = 0; address = 7'd5;
    tick();
    reset = 1; we = 1; data_w = 16'h1234; choose = 1; address = 7'd7;
    tick();
    reset = 0; we = 0; k = 0;
    n_cmp++;
    if (dut.address_r !== 7'd0 || dut.address_w !== 7'd0) begin
      n_err++;
      $display("FAIL rp_addr: got %0d/%0d want 0/0",
               dut.address_r, dut.address_w);
    end
    choose = 1; address = 7'd5;
    tick();
    choose = 0;
    tick();
    n_cmp++;
    if (bcd !== 7'h79) begin
      n_err++; $display("FAIL rp_nowrite: got %h want 79", bcd);
    end
  endtask

`ifdef REG_FILE_SCAN_EN
  task automatic test_auto_scan();
    do_reset();
    mode = 1; choose = 1; address = 7'd127;
    tick();
    choose = 0; address = 7'd0;
    for (int j = 2; j <= 5; j++) begin
      tick();
      n_cmp++;
      if (dut.address_r !== ((j == 5) ? 7'd0 : 7'd127)) begin
        n_err++; $display("FAIL scan_ar k=%0d: got %0d", k, dut.address_r);
      end
      if (j == 2 || j == 5) begin
        n_cmp++;
        if (dp !== (j == 5)) begin
          n_err++; $display("FAIL scan_dp k=%0d: got %b want %b", k, dp, j == 5);
        end
      end
    end
  endtask

  task automatic test_load_vs_scan();
    for (int j = 6; j <= 8; j++) begin
      tick();
      n_cmp++;
      if (dut.address_r !== 7'd0) begin
        n_err++; $display("FAIL col_pre k=%0d: got %0d want 0", k, dut.address_r);
      end
    end
    choose = 1; address = 7'd9;
    tick();
    choose = 0; address = 7'd0;
    n_cmp++;
    if (dut.address_r !== 7'd9) begin
      n_err++; $display("FAIL col_load: got %0d want 9", dut.address_r);
    end
    for (int j = 10; j <= 13; j++) begin
      tick();
      n_cmp++;
      if (dut.address_r !== ((j == 13) ? 7'd10 : 7'd9)) begin
        n_err++; $display("FAIL col_next k=%0d: got %0d", k, dut.address_r);
      end
    end
    mode = 0;
  endtask
`else
  task automatic test_mode_ignored();
    do_reset();
    choose = 1; address = 7'd33;
    tick();
    choose = 0; address = 7'd0; mode = 1;
    for (int j = 0; j < 100; j++) begin
      tick();
      n_cmp++;
      if (dut.address_r !== 7'd33 || dp !== 1'b1) begin
        n_err++;
        $display("FAIL mode_ign k=%0d: got %0d/%b want 33/1",
                 k, dut.address_r, dp);
      end
    end
    mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid();
    test_write_displayed();
    test_reset_priority();
`ifdef REG_FILE_SCAN_EN
    test_auto_scan();
    test_load_vs_scan();
`else
    test_mode_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
